// File: rtl/proc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// proc_ctrl_pkg
//  Shared types and constants for the processor controller slice.
//  Contents:
//   state_t          4-bit controller state, explicit encodings INIT=0..HALT=9
//   OP_NOOP..OP_HALT opcode values found in IR[15:12]
//   ALU_PASS/ADD/SUB ALU operation selects driven on Alu_s0
//   IR_WIDTH, DADDR_WIDTH, RADDR_WIDTH  fixed instruction-format field widths
//   is_legal_op()    true for opcodes the datapath actually implements
// -----------------------------------------------------------------------------
package proc_ctrl_pkg;

   localparam int IR_WIDTH    = 16;
   localparam int DADDR_WIDTH = 8;
   localparam int RADDR_WIDTH = 4;

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LOAD_A = 4'd4,
      S_LOAD_B = 4'd5,
      S_STORE  = 4'd6,
      S_ADD    = 4'd7,
      S_SUB    = 4'd8,
      S_HALT   = 4'd9
   } state_t;

   localparam logic [3:0] OP_NOOP  = 4'b0000;
   localparam logic [3:0] OP_STORE = 4'b0001;
   localparam logic [3:0] OP_LOAD  = 4'b0010;
   localparam logic [3:0] OP_ADD   = 4'b0011;
   localparam logic [3:0] OP_SUB   = 4'b0100;
   localparam logic [3:0] OP_HALT  = 4'b0101;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;

   // Opcodes 0110..1111 are unassigned.
   function automatic logic is_legal_op(input logic [3:0] op);
      return (op <= OP_HALT);
   endfunction

endpackage

// File: rtl/ir_field_decode.sv
// -----------------------------------------------------------------------------
// ir_field_decode
//  Purely combinational split of the 16-bit instruction into its fields.
//  The register-A field moves with the opcode: STORE carries its source
//  register in IR[3:0], ADD/SUB carry operand A in IR[11:8].
//  Ports:
//   IR      in  16  instruction register contents
//   opcode  out 4   IR[15:12]
//   d_addr  out 8   data-memory address IR[11:4]
//   ra      out 4   RF read port A address
//   rb      out 4   RF read port B address IR[7:4]
//   rw      out 4   RF write address IR[3:0]
// -----------------------------------------------------------------------------
module ir_field_decode
   import proc_ctrl_pkg::*;
(
   input  logic [IR_WIDTH-1:0]    IR,
   output logic [3:0]             opcode,
   output logic [DADDR_WIDTH-1:0] d_addr,
   output logic [RADDR_WIDTH-1:0] ra,
   output logic [RADDR_WIDTH-1:0] rb,
   output logic [RADDR_WIDTH-1:0] rw
);

   assign opcode = IR[15:12];
   assign d_addr = IR[11:4];
   assign ra     = (IR[15:12] == OP_STORE) ? IR[3:0] : IR[11:8];
   assign rb     = IR[7:4];
   assign rw     = IR[3:0];

endmodule

// File: rtl/proc_controller.sv
// -----------------------------------------------------------------------------
// proc_controller
//  Moore FSM sequencing the simple processor datapath:
//  Fetch -> Decode -> Execute (1 cycle, or 2 for LOAD).
//  Address outputs follow IR combinationally in every state; only the
//  enables and the ALU select are gated by state. No output depends on Clr.
//  Optional build macro: CTRL_ILLEGAL_TRAP_EN
//   defined   -> unassigned opcodes trap to HALT and raise Illegal
//   undefined -> unassigned opcodes execute as NOOP, no Illegal port
//  Ports:
//   Clk         in   1        system clock, rising edge
//   Clr         in   1        synchronous active-high reset
//   IR          in   IR_W     instruction register contents
//   PC_clr      out  1        clear program counter
//   PC_up       out  1        increment program counter
//   IR_ld       out  1        load instruction register
//   D_addr      out  DADDR_W  data-memory address
//   D_wr        out  1        data-memory write enable
//   RF_s        out  1        RF write-data select (1 = memory, 0 = ALU)
//   RF_W_addr   out  RADDR_W  RF write address
//   RF_W_en     out  1        RF write enable
//   RF_Ra_addr  out  RADDR_W  RF read port A address
//   RF_Rb_addr  out  RADDR_W  RF read port B address
//   Alu_s0      out  3        ALU op select
//   State       out  4        current state encoding
//   Illegal     out  1        (trap build only) halted on unassigned opcode
// -----------------------------------------------------------------------------
module proc_controller
   import proc_ctrl_pkg::*;
#(
   parameter int IR_W    = IR_WIDTH,
   parameter int DADDR_W = DADDR_WIDTH,
   parameter int RADDR_W = RADDR_WIDTH
) (
   input  logic               Clk,
   input  logic               Clr,
   input  logic [IR_W-1:0]    IR,
   output logic               PC_clr,
   output logic               PC_up,
   output logic               IR_ld,
   output logic [DADDR_W-1:0] D_addr,
   output logic               D_wr,
   output logic               RF_s,
   output logic [RADDR_W-1:0] RF_W_addr,
   output logic               RF_W_en,
   output logic [RADDR_W-1:0] RF_Ra_addr,
   output logic [RADDR_W-1:0] RF_Rb_addr,
   output logic [2:0]         Alu_s0,
`ifdef CTRL_ILLEGAL_TRAP_EN
   output logic               Illegal,
`endif
   output logic [3:0]         State
);

   state_t     state, state_nxt;
   logic [3:0] opcode;

   // ---------------------------------------------------------------- fields
   ir_field_decode u_ir_field_decode (
      .IR     (IR),
      .opcode (opcode),
      .d_addr (D_addr),
      .ra     (RF_Ra_addr),
      .rb     (RF_Rb_addr),
      .rw     (RF_W_addr)
   );

   // ---------------------------------------------------------- state register
   // NOTE: sequential state uses non-blocking assignment so every flop samples
   // its pre-edge value; blocking here would create order-dependent races.
   always_ff @(posedge Clk) begin
      if (Clr) state <= S_INIT;
      else     state <= state_nxt;
   end

`ifdef CTRL_ILLEGAL_TRAP_EN
   // Sticky flag remembering why HALT was entered; only Clr clears it.
   logic illegal_q;

   always_ff @(posedge Clk) begin
      if (Clr)
         illegal_q <= 1'b0;
      else if (state == S_DECODE && !is_legal_op(opcode))
         illegal_q <= 1'b1;
   end

   assign Illegal = illegal_q && (state == S_HALT);
`endif

   // --------------------------------------------------------- next state
   always_comb begin
      // NOTE: assign a default before the case so no path leaves state_nxt
      // unassigned, which would otherwise infer a latch.
      state_nxt = state;
      unique case (state)
         S_INIT:   state_nxt = S_FETCH;
         S_FETCH:  state_nxt = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_NOOP:  state_nxt = S_NOOP;
               OP_STORE: state_nxt = S_STORE;
               OP_LOAD:  state_nxt = S_LOAD_A;
               OP_ADD:   state_nxt = S_ADD;
               OP_SUB:   state_nxt = S_SUB;
               OP_HALT:  state_nxt = S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
               default:  state_nxt = S_HALT;
`else
               default:  state_nxt = S_NOOP;
`endif
            endcase
         end
         S_NOOP:   state_nxt = S_FETCH;
         S_LOAD_A: state_nxt = S_LOAD_B;
         S_LOAD_B: state_nxt = S_FETCH;
         S_STORE:  state_nxt = S_FETCH;
         S_ADD:    state_nxt = S_FETCH;
         S_SUB:    state_nxt = S_FETCH;
         S_HALT:   state_nxt = S_HALT;
         default:  state_nxt = S_INIT;
      endcase
   end

   // ---------------------------------------------------- state-gated enables
   always_comb begin
      PC_clr  = 1'b0;
      PC_up   = 1'b0;
      IR_ld   = 1'b0;
      D_wr    = 1'b0;
      RF_s    = 1'b0;
      RF_W_en = 1'b0;
      Alu_s0  = ALU_PASS;
      unique case (state)
         S_INIT:  PC_clr = 1'b1;
         S_FETCH: begin
            IR_ld = 1'b1;
            PC_up = 1'b1;
         end
         S_STORE: begin
            Alu_s0 = ALU_PASS;
            D_wr   = 1'b1;
         end
         // LOAD_A only presents the address; memory data is valid in LOAD_B.
         S_LOAD_B: begin
            RF_s    = 1'b1;
            RF_W_en = 1'b1;
         end
         S_ADD: begin
            Alu_s0  = ALU_ADD;
            RF_W_en = 1'b1;
         end
         S_SUB: begin
            Alu_s0  = ALU_SUB;
            RF_W_en = 1'b1;
         end
         default: ;
      endcase
   end

   assign State = state;

endmodule
